// File: rtl/led_blinker.sv
// LED blink sequencer: N on/off blinks per trigger, then a one-cycle DONE pulse.
// Optional one-deep pending request is compiled in when LED_PENDING_EN is defined.
module led_blinker #(
    parameter bit          ACTIVE_STATE    = 1'b1,
    parameter int unsigned CLOCKS_PER_USEC = 100,
    parameter int unsigned ON_MSEC         = 100,
    parameter int unsigned OFF_MSEC        = 100
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       TRIGGER,
    input  logic [3:0] COUNT,
    output logic       PIN,
    output logic       BUSY,
    output logic       DONE
);

    localparam int unsigned ON_PERIOD  = CLOCKS_PER_USEC * ON_MSEC * 1000;
    localparam int unsigned OFF_PERIOD = CLOCKS_PER_USEC * OFF_MSEC * 1000;
    localparam int unsigned MAX_PERIOD = (ON_PERIOD > OFF_PERIOD) ? ON_PERIOD : OFF_PERIOD;
    localparam int unsigned CW         = $clog2(MAX_PERIOD + 1);
    localparam logic [CW-1:0] ON_LAST  = CW'(ON_PERIOD - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(OFF_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ON     = 2'd1,
        OFF    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t        state_q     = IDLE;
    logic [CW-1:0] cnt_q       = '0;
    logic [3:0]    remaining_q = '0;
    logic          pin_q       = ~ACTIVE_STATE;
    logic          busy_q      = 1'b0;
    logic          done_q      = 1'b0;
    logic          req_d;

`ifdef LED_PENDING_EN
    logic          pend_q      = 1'b0;
    logic [3:0]    pend_cnt_q  = '0;
`endif

    assign req_d = TRIGGER && (COUNT != '0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            remaining_q <= '0;
            pin_q       <= ~ACTIVE_STATE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef LED_PENDING_EN
            pend_q      <= 1'b0;
            pend_cnt_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_d) begin
                        state_q     <= ON;
                        remaining_q <= COUNT;
                        cnt_q       <= '0;
                        pin_q       <= ACTIVE_STATE;
                        busy_q      <= 1'b1;
                    end
                end
                ON: begin
                    if (cnt_q == ON_LAST) begin
                        state_q     <= OFF;
                        cnt_q       <= '0;
                        pin_q       <= ~ACTIVE_STATE;
                        remaining_q <= remaining_q - 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                OFF: begin
                    if (cnt_q == OFF_LAST) begin
                        cnt_q <= '0;
                        if (remaining_q != '0) begin
                            state_q <= ON;
                            pin_q   <= ACTIVE_STATE;
                        end else begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FINISH: begin
`ifdef LED_PENDING_EN
                    // A request landing in the DONE cycle is the newest one and supersedes the stored one.
                    if (req_d) begin
                        state_q     <= ON;
                        remaining_q <= COUNT;
                        pin_q       <= ACTIVE_STATE;
                        pend_q      <= 1'b0;
                    end else if (pend_q) begin
                        state_q     <= ON;
                        remaining_q <= pend_cnt_q;
                        pin_q       <= ACTIVE_STATE;
                        pend_q      <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
`else
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
`ifdef LED_PENDING_EN
            if (req_d && (state_q == ON || state_q == OFF)) begin
                pend_q     <= 1'b1;
                pend_cnt_q <= COUNT;
            end
`endif
        end
    end

    assign PIN  = pin_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_led_blinker.sv
// Randomized self-checking bench for led_blinker against a timeline model of the blink sequence.
module tb_led_blinker;

    localparam int ON_P  = 1000;
    localparam int OFF_P = 2000;
    localparam int BLINK = ON_P + OFF_P;
`ifdef LED_PENDING_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       TRIGGER = 1'b0;
    logic [3:0] COUNT = '0;
    logic       PIN0, BUSY0, DONE0;
    logic       PIN1, BUSY1, DONE1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    led_blinker #(.ACTIVE_STATE(1'b1), .CLOCKS_PER_USEC(1), .ON_MSEC(1), .OFF_MSEC(2)) dut_hi (
        .CLK(clk), .RESET(RESET), .TRIGGER(TRIGGER), .COUNT(COUNT),
        .PIN(PIN0), .BUSY(BUSY0), .DONE(DONE0)
    );

    led_blinker #(.ACTIVE_STATE(1'b0), .CLOCKS_PER_USEC(1), .ON_MSEC(1), .OFF_MSEC(2)) dut_lo (
        .CLK(clk), .RESET(RESET), .TRIGGER(TRIGGER), .COUNT(COUNT),
        .PIN(PIN1), .BUSY(BUSY1), .DONE(DONE1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a sequence of N blinks is a timeline t = 0 .. N*BLINK, DONE at its last step.
    bit m_active = 1'b0;
    int m_t = 0;
    int m_n = 0;
    bit m_pend = 1'b0;
    int m_pend_n = 0;

    always @(posedge clk) begin
        if (RESET) begin
            m_active = 1'b0; m_t = 0; m_n = 0; m_pend = 1'b0;
        end else if (!m_active) begin
            if (TRIGGER && COUNT != 0) begin
                m_active = 1'b1; m_t = 0; m_n = int'(COUNT);
            end
        end else if (m_t == m_n * BLINK) begin
            if (PEND && TRIGGER && COUNT != 0) begin
                m_t = 0; m_n = int'(COUNT); m_pend = 1'b0;
            end else if (PEND && m_pend) begin
                m_t = 0; m_n = m_pend_n; m_pend = 1'b0;
            end else begin
                m_active = 1'b0;
            end
        end else begin
            m_t++;
            if (PEND && TRIGGER && COUNT != 0) begin
                m_pend = 1'b1; m_pend_n = int'(COUNT);
            end
        end
    end

    int pulses = 0, dones = 0, busy_cyc = 0, busy_starts = 0;
    int run = 0, min_len = 1 << 30, max_len = 0;
    logic pin_prev = 1'b0, busy_prev = 1'b0;

    always @(negedge clk) begin
        logic e_pin, e_busy, e_done;
        e_pin  = m_active && (m_t < m_n * BLINK) && ((m_t % BLINK) < ON_P);
        e_busy = m_active;
        e_done = m_active && (m_t == m_n * BLINK);
        check("cycle", {26'd0, PIN0, PIN1, BUSY0, BUSY1, DONE0, DONE1},
              {26'd0, e_pin, ~e_pin, e_busy, e_busy, e_done, e_done});
        if (PIN0 && !pin_prev) pulses++;
        if (PIN0) run++;
        else if (pin_prev) begin
            if (run < min_len) min_len = run;
            if (run > max_len) max_len = run;
            run = 0;
        end
        if (DONE0) dones++;
        if (BUSY0) busy_cyc++;
        if (BUSY0 && !busy_prev) busy_starts++;
        pin_prev  = PIN0;
        busy_prev = BUSY0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            COUNT = 4'($urandom);
            tick();
        end
    endtask

    task automatic trig(input logic [3:0] c);
        TRIGGER = 1'b1;
        COUNT   = c;
        tick();
        TRIGGER = 1'b0;
        COUNT   = 4'($urandom);
    endtask

    task automatic clear_stats();
        pulses = 0; dones = 0; busy_cyc = 0; busy_starts = 0;
        run = 0; min_len = 1 << 30; max_len = 0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (BUSY0 && k < 50000) begin
            COUNT = 4'($urandom);
            tick();
            k++;
        end
        check("busy_timeout", {31'd0, k < 50000}, 32'd1);
        idle(2);
    endtask

    initial begin
        int c;
        idle(3);
        RESET = 1'b0;
        check("rst_pin_hi", {31'd0, PIN0}, 32'd0);
        check("rst_pin_lo", {31'd0, PIN1}, 32'd1);
        check("rst_busy", {31'd0, BUSY0}, 32'd0);
        check("rst_done", {31'd0, DONE0}, 32'd0);
        idle(6);

        // single blink
        clear_stats();
        trig(4'd1);
        check("start_pin", {31'd0, PIN0}, 32'd1);
        check("start_busy", {31'd0, BUSY0}, 32'd1);
        wait_idle();
        check("b1_pulses", pulses, 32'd1);
        check("b1_len", max_len, 32'd1000);
        check("b1_dones", dones, 32'd1);
        check("b1_busy", busy_cyc, 32'd3001);

        // zero count is ignored
        clear_stats();
        trig(4'd0);
        idle(5);
        check("z_busy", busy_cyc, 32'd0);
        check("z_pulses", pulses, 32'd0);
        check("z_dones", dones, 32'd0);

        // three blinks
        clear_stats();
        trig(4'd3);
        wait_idle();
        check("b3_pulses", pulses, 32'd3);
        check("b3_min", min_len, 32'd1000);
        check("b3_max", max_len, 32'd1000);
        check("b3_busy", busy_cyc, 32'd9001);
        check("b3_dones", dones, 32'd1);

        // randomized counts and gaps
        for (int r = 0; r < 3; r++) begin
            c = int'($urandom_range(1, 3));
            clear_stats();
            idle(int'($urandom_range(1, 20)));
            trig(4'(c));
            wait_idle();
            check("rnd_pulses", pulses, c);
            check("rnd_len", max_len, 32'd1000);
            check("rnd_busy", busy_cyc, c * BLINK + 1);
            check("rnd_dones", dones, 32'd1);
        end

        // reset during the 500th cycle of the ON phase
        clear_stats();
        trig(4'd2);
        idle(499);
        RESET = 1'b1;
        tick();
        check("mrst_pin", {31'd0, PIN0}, 32'd0);
        check("mrst_pin_lo", {31'd0, PIN1}, 32'd1);
        check("mrst_busy", {31'd0, BUSY0}, 32'd0);
        RESET = 1'b0;
        idle(10);
        check("mrst_dones", dones, 32'd0);

        // retrigger while busy
        clear_stats();
        trig(4'd1);
        idle(200);
        trig(4'd2);
        wait_idle();
        check("rt_pulses", pulses, PEND ? 32'd3 : 32'd1);
        check("rt_dones", dones, PEND ? 32'd2 : 32'd1);
        check("rt_busy_starts", busy_starts, 32'd1);
        check("rt_busy", busy_cyc, PEND ? 32'd9002 : 32'd3001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_blinker.md
LED_BLINKER -- requirements
Module: led_blinker

Interface
REQ-001 SHALL have parameter ACTIVE_STATE, default 1: PIN level meaning "LED on"; the inactive level is the inverse.
REQ-002 SHALL have parameter CLOCKS_PER_USEC, default 100: CLK cycles per microsecond.
REQ-003 SHALL have parameter ON_MSEC, default 100: duration of each on phase, in ms.
REQ-004 SHALL have parameter OFF_MSEC, default 100: duration of each off phase, in ms.
REQ-005 SHALL have port CLK, input, 1 bit: the only clock; all logic on its rising edge.
REQ-006 SHALL have port RESET, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port TRIGGER, input, 1 bit: single-cycle request to start a blink sequence, sampled on every CLK edge.
REQ-008 SHALL have port COUNT, input, 4 bits: number of blinks, sampled in the cycle TRIGGER is accepted.
REQ-009 SHALL have port PIN, output, 1 bit: registered LED drive.
REQ-010 SHALL have port BUSY, output, 1 bit: high while a sequence is in progress.
REQ-011 SHALL have port DONE, output, 1 bit: one-cycle pulse when a sequence completes.

Function
REQ-012 SHALL derive ON_PERIOD = CLOCKS_PER_USEC*ON_MSEC*1000 and OFF_PERIOD = CLOCKS_PER_USEC*OFF_MSEC*1000 cycles, with the phase counter width = $clog2(max(ON_PERIOD,OFF_PERIOD)+1).
REQ-013 SHALL implement states IDLE, ON, OFF, FINISH.
REQ-014 SHALL, in IDLE with TRIGGER=1 and COUNT!=0 at edge t, latch COUNT into a remaining-blinks register and enter ON; PIN=ACTIVE_STATE and BUSY=1 from edge t+1.
REQ-015 SHALL ignore a TRIGGER with COUNT=0 in IDLE: no state change and no DONE pulse.
REQ-016 SHALL hold PIN active for exactly ON_PERIOD cycles in ON, then enter OFF and decrement the remaining-blinks count.
REQ-017 SHALL hold PIN inactive for exactly OFF_PERIOD cycles in OFF, then enter ON if remaining>0, otherwise FINISH; a trailing off phase always follows the last blink.
REQ-018 SHALL, in FINISH, assert DONE for exactly one cycle with BUSY still 1, then enter IDLE with BUSY=0 on the next edge.
REQ-019 SHALL drive PIN inactive in IDLE, OFF and FINISH.
REQ-020 SHALL, with COUNT=N, produce exactly N active pulses, and total BUSY time = N*(ON_PERIOD+OFF_PERIOD)+1 cycles.
REQ-021 SHALL never let COUNT changes outside the acceptance cycle affect a sequence in progress.

Reset
REQ-022 SHALL, with RESET high at a CLK edge, force IDLE, PIN=inactive level, BUSY=0, DONE=0, counters=0 and the pending flag clear, including mid-sequence; RESET has priority over TRIGGER in the same cycle.
REQ-023 SHALL have the same power-up register values as the reset values.

Configuration
REQ-024 SHALL compile a one-deep pending request only when LED_PENDING_EN is defined.
REQ-025 SHALL, with LED_PENDING_EN defined: store a TRIGGER with COUNT!=0 that arrives while BUSY=1, keeping the newest request; after FINISH, go directly to ON with the stored COUNT (no IDLE cycle), so BUSY stays high and DONE pulses once per sequence.
REQ-026 SHALL, without LED_PENDING_EN defined, ignore any TRIGGER while BUSY=1.

Verification
Benches use CLOCKS_PER_USEC=1, ON_MSEC=1, OFF_MSEC=2, giving ON_PERIOD=1000 and OFF_PERIOD=2000.
REQ-027 SHALL cover a single blink: TRIGGER at cycle 10 with COUNT=1 -> PIN active for cycles 11-1010, inactive 1011-3010, DONE at cycle 3011, BUSY low from 3012.
REQ-028 SHALL cover three blinks: COUNT=3 -> exactly 3 active pulses of 1000 cycles each, and BUSY high for 9001 cycles.
REQ-029 SHALL cover zero count: TRIGGER with COUNT=0 -> BUSY, PIN and DONE unchanged.
REQ-030 SHALL cover reset mid-sequence: RESET pulsed at cycle 500 of the ON phase -> PIN inactive and BUSY=0 the next cycle, and no DONE pulse.
REQ-031 SHALL cover a retrigger while busy: TRIGGER COUNT=2 during a COUNT=1 sequence -> with LED_PENDING_EN, 3 pulses total, 2 DONE pulses and BUSY continuous; without it, 1 pulse and 1 DONE pulse.
REQ-032 SHALL cover polarity: ACTIVE_STATE=0 -> PIN idles high and is low during ON phases.
